// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : phase encoding, timing bundle, 640x480 defaults and colour bars
// Rev 1.0
// ============================================================================
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } phase_t;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t VGA_H_640 = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t VGA_V_480 = '{active: 480, fp: 10, sync: 2,  bp: 33};

  localparam int         NUM_BARS   = 8;
  localparam logic [3:0] COLOUR_ON  = 4'hF;
  localparam logic [3:0] COLOUR_OFF = 4'h0;

  function automatic int timing_total(input timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Bar index bits map to {R,G,B}: 0 black, 1 blue, 2 green ... 7 white.
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    c = {COLOUR_OFF, COLOUR_OFF, COLOUR_OFF};
    if (idx[2]) c[11:8] = COLOUR_ON;
    if (idx[1]) c[7:4]  = COLOUR_ON;
    if (idx[0]) c[3:0]  = COLOUR_ON;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// vga_axis_counter : wrapping position counter with ACTIVE/FP/SYNC/BP phase FSM
// Rev 1.0
// ============================================================================
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int LEN_ACTIVE = 640,
  parameter int LEN_FP     = 16,
  parameter int LEN_SYNC   = 96,
  parameter int LEN_BP     = 48,
  parameter int W          = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  output logic [W-1:0] cnt,
  output phase_t       phase,
  output logic         wrap
);

  localparam timing_t    T           = '{active: LEN_ACTIVE, fp: LEN_FP, sync: LEN_SYNC, bp: LEN_BP};
  localparam int         TOTAL       = timing_total(T);
  localparam logic [W-1:0] LAST_ACTIVE = W'(LEN_ACTIVE - 1);
  localparam logic [W-1:0] LAST_FP     = W'(LEN_ACTIVE + LEN_FP - 1);
  localparam logic [W-1:0] LAST_SYNC   = W'(LEN_ACTIVE + LEN_FP + LEN_SYNC - 1);
  localparam logic [W-1:0] LAST        = W'(TOTAL - 1);

  if (LEN_ACTIVE < 1 || LEN_FP < 1 || LEN_SYNC < 1 || LEN_BP < 1) begin : g_bad_len
    $error("vga_axis_counter: every phase length must be at least 1");
  end
  if ((TOTAL - 1) >= (1 << W)) begin : g_bad_width
    $error("vga_axis_counter: counter width too small for the line/frame total");
  end

  phase_t phase_next;

  assign wrap = advance && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= ACTIVE;
    end else begin
      phase <= phase_next;
      if (advance) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
    end
  end

  // Phase moves on the last count of the current phase, so it always matches cnt.
  always_comb begin
    phase_next = phase;
    if (advance) begin
      case (phase)
        ACTIVE:  if (cnt == LAST_ACTIVE) phase_next = FP;
        FP:      if (cnt == LAST_FP)     phase_next = SYNC;
        SYNC:    if (cnt == LAST_SYNC)   phase_next = BP;
        BP:      if (cnt == LAST)        phase_next = ACTIVE;
        default:                         phase_next = ACTIVE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : registered hsync/vsync/de/x/y video timing generator
// VGA_TIMING_TEST_PATTERN_EN adds the rgb colour-bar output.  Rev 1.0
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_640.active,
  parameter int H_FP      = VGA_H_640.fp,
  parameter int H_SYNC    = VGA_H_640.sync,
  parameter int H_BP      = VGA_H_640.bp,
  parameter int V_ACTIVE  = VGA_V_480.active,
  parameter int V_FP      = VGA_V_480.fp,
  parameter int V_SYNC    = VGA_V_480.sync,
  parameter int V_BP      = VGA_V_480.bp,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int XW        = 10,
  parameter int YW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
  ,
  output logic [11:0]   rgb
`endif
);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  phase_t        h_phase;
  phase_t        v_phase;
  logic          h_wrap;
  logic          v_wrap_unused;
  logic          de_next;

  vga_axis_counter #(
    .LEN_ACTIVE (H_ACTIVE),
    .LEN_FP     (H_FP),
    .LEN_SYNC   (H_SYNC),
    .LEN_BP     (H_BP),
    .W          (XW)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (1'b1),
    .cnt     (h_cnt),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .LEN_ACTIVE (V_ACTIVE),
    .LEN_FP     (V_FP),
    .LEN_SYNC   (V_SYNC),
    .LEN_BP     (V_BP),
    .W          (YW)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (h_wrap),
    .cnt     (v_cnt),
    .phase   (v_phase),
    .wrap    (v_wrap_unused)
  );

  assign de_next = (h_phase == ACTIVE) && (v_phase == ACTIVE);

  // Every output is the decode of the current counters, one clock late.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (h_phase == SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (v_phase == SYNC) ? VSYNC_POL : ~VSYNC_POL;
      de          <= de_next;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / NUM_BARS;

  logic [2:0] bar_idx;

  // Threshold chain instead of a divide by a non-power-of-two bar width.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (int'(h_cnt) >= k * BAR_W) bar_idx = 3'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb <= 12'h000;
    end else begin
      rgb <= de_next ? bar_colour(bar_idx) : 12'h000;
    end
  end
`endif

endmodule
`default_nettype wire
